bf_iter_sequencer: RTL and testbench

- Control sequencer directly upstream of the level-1 compare/update unit in the 32x32 Bellman-Ford array.
- Drives `phase_counter` and `step_counter`, and frames each relaxation iteration.
- Collects "distance changed" feedback from the update pipeline and stops on convergence or after NUM_NODES-1 iterations.
- Reports completion to the top-level controller with a one-cycle `done` pulse.

---
 rtl/bf_pkg.sv | 17 +
 rtl/bf_beat_counter.sv | 39 +++
 rtl/bf_iter_sequencer.sv | 144 ++++++++++++++
 tb/tb_bf_iter_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford array control path: sequencer FSM
// encoding and the phase/step beat geometry used by the level-1/level-2 units.
package bf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bf_state_e;

  localparam int PHASE_W        = 1;
  localparam int STEP_W         = 2;
  localparam int BEAT_W         = PHASE_W + STEP_W;
  localparam int BEATS_PER_ITER = 8;

endpackage

// File: rtl/bf_beat_counter.sv
// Stall-aware beat counter: phase is the low bit (inner loop), step the upper
// bits (outer loop); wraps to 0 after the last beat of an iteration.
module bf_beat_counter
  import bf_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [PHASE_W-1:0] phase,
  output logic [STEP_W-1:0]  step,
  output logic               last
);

  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (en) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign phase = beat_q[PHASE_W-1:0];
  assign step  = beat_q[BEAT_W-1:PHASE_W];
  assign last  = (beat_q == BEAT_W'(BEATS_PER_ITER - 1));

endmodule

// File: rtl/bf_iter_sequencer.sv
// Bellman-Ford relaxation iteration sequencer. Optional negative-cycle check
// iteration is enabled by defining BF_NEG_CYCLE_CHECK_EN.
module bf_iter_sequencer
  import bf_pkg::*;
#(
  parameter int NUM_NODES    = 32,
  parameter int ITER_W       = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               upd_valid,
  input  logic               upd_changed,
  output logic [PHASE_W-1:0] phase_counter,
  output logic [STEP_W-1:0]  step_counter,
  output logic               seq_valid,
  output logic [ITER_W-1:0]  iter_idx,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic               neg_cycle
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  bf_state_e         state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              chg_q, chg_d;
  logic              conv_q, conv_d;
  logic              neg_q, neg_d;

  logic beat_clr;
  logic beat_en;
  logic beat_last;
  logic upd_hit;
  logic chg_now;

  assign beat_clr = (state_q == ST_IDLE) && start;
  assign beat_en  = (state_q == ST_RUN) && !stall;
  assign upd_hit  = upd_valid & upd_changed;
  assign chg_now  = chg_q | upd_hit;

  bf_beat_counter u_beat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat_clr),
    .en    (beat_en),
    .phase (phase_counter),
    .step  (step_counter),
    .last  (beat_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      drn_q   <= '0;
      chg_q   <= 1'b0;
      conv_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      drn_q   <= drn_d;
      chg_q   <= chg_d;
      conv_q  <= conv_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    drn_d   = drn_q;
    chg_d   = chg_q;
    conv_d  = conv_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          iter_d  = '0;
          chg_d   = 1'b0;
          conv_d  = 1'b0;
          neg_d   = 1'b0;
        end
      end
      ST_RUN: begin
        chg_d = chg_now;
        if (beat_en && beat_last) begin
          state_d = ST_DRAIN;
          drn_d   = DRN_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        chg_d = chg_now;
        if (drn_q != '0) begin
          drn_d = drn_q - 1'b1;
        end else if (!chg_now) begin
          state_d = ST_DONE;
          conv_d  = 1'b1;
`ifdef BF_NEG_CYCLE_CHECK_EN
        end else if (iter_q == ITER_W'(NUM_NODES - 1)) begin
          // Still relaxing after NUM_NODES-1 passes: a negative cycle exists.
          state_d = ST_DONE;
          conv_d  = 1'b0;
          neg_d   = 1'b1;
`else
        end else if (iter_q == ITER_W'(NUM_NODES - 2)) begin
          state_d = ST_DONE;
          conv_d  = 1'b0;
`endif
        end else begin
          state_d = ST_RUN;
          iter_d  = iter_q + 1'b1;
          chg_d   = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    seq_valid = (state_q == ST_RUN) && !stall;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    iter_idx  = iter_q;
    converged = conv_q;
`ifdef BF_NEG_CYCLE_CHECK_EN
    neg_cycle = neg_q;
`else
    neg_cycle = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bf_iter_sequencer.sv
// Directed bench for bf_iter_sequencer (NUM_NODES=32, DRAIN_CYCLES=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_bf_iter_sequencer;
  import bf_pkg::*;

  localparam int NUM_NODES    = 32;
  localparam int ITER_W       = 5;
  localparam int DRAIN_CYCLES = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stall;
  logic               upd_valid;
  logic               upd_changed;
  logic [PHASE_W-1:0] phase_counter;
  logic [STEP_W-1:0]  step_counter;
  logic               seq_valid;
  logic [ITER_W-1:0]  iter_idx;
  logic               busy;
  logic               done;
  logic               converged;
  logic               neg_cycle;

  int n_chk;
  int n_bad;

  bf_iter_sequencer #(
    .NUM_NODES    (NUM_NODES),
    .ITER_W       (ITER_W),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .upd_valid     (upd_valid),
    .upd_changed   (upd_changed),
    .phase_counter (phase_counter),
    .step_counter  (step_counter),
    .seq_valid     (seq_valid),
    .iter_idx      (iter_idx),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .neg_cycle     (neg_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, let combinational outputs settle.
  task automatic cyc(input logic st, input logic sl, input logic uv, input logic uc);
    @(negedge clk);
    start       = st;
    stall       = sl;
    upd_valid   = uv;
    upd_changed = uc;
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, phase_counter, step_counter, seq_valid, iter_idx,
            busy, done, converged, neg_cycle};
  endfunction

  // Unstalled iteration with index i; optional change pulse on first DRAIN cycle.
  task automatic iteration(input int i, input logic pulse);
    for (int c = 1; c <= 8 + DRAIN_CYCLES; c++) begin
      cyc(1'b0, 1'b0, pulse && (c == 9), pulse && (c == 9));
      if (c == 1) begin
        chk("it_idx", iter_idx, i);
        chk("it_first_vld", seq_valid, 1);
      end
    end
  endtask

  // Quiet run from start; checks exact beat order, drain and done timing.
  task automatic quiet_run(input string tag);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, "_c0_busy"}, busy, 0);
    for (int c = 1; c <= 14; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (c <= 8) begin
        chk({tag, "_vld"}, seq_valid, 1);
        chk({tag, "_phase"}, phase_counter, (c - 1) % 2);
        chk({tag, "_step"}, step_counter, (c - 1) / 2);
      end else if (c <= 12) begin
        chk({tag, "_drain_vld"}, seq_valid, 0);
        chk({tag, "_drain_ph_st"}, {phase_counter, step_counter}, 0);
      end
      chk({tag, "_done"}, done, (c == 13));
      chk({tag, "_busy"}, busy, (c <= 13));
      if (c >= 13) begin
        chk({tag, "_conv"}, converged, 1);
        chk({tag, "_iter"}, iter_idx, 0);
      end
    end
  endtask

  initial begin
    int eb;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    upd_valid = 1'b0;
    upd_changed = 1'b0;

    // Asynchronous reset mid-cycle
    #13;
    rst_n = 1'b0;
    #1;
    chk("rst_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_busy", busy, 0);
    chk("idle_vld", seq_valid, 0);
    chk("idle_outs", all_outs(), 0);

    // Convergence on first iteration
    quiet_run("conv0");

    // Stall at cycles 3-5
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    eb = 0;
    for (int c = 1; c <= 17; c++) begin
      logic sl;
      sl = (c >= 3 && c <= 5);
      cyc(1'b0, sl, 1'b0, 1'b0);
      if (c <= 11) begin
        chk("stl_vld", seq_valid, !sl);
        chk("stl_beat", {step_counter, phase_counter}, eb);
        if (!sl) eb++;
      end
      chk("stl_done", done, (c == 16));
    end
    chk("stl_beats", eb, 8);

    // Change in every iteration: run to iteration limit
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifndef BF_NEG_CYCLE_CHECK_EN
    for (int i = 0; i <= NUM_NODES - 2; i++) iteration(i, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lim_done", done, 1);
    chk("lim_iter", iter_idx, NUM_NODES - 2);
    chk("lim_conv", converged, 0);
    chk("lim_neg", neg_cycle, 0);
`else
    for (int i = 0; i <= NUM_NODES - 1; i++) iteration(i, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("neg_done", done, 1);
    chk("neg_iter", iter_idx, NUM_NODES - 1);
    chk("neg_conv", converged, 0);
    chk("neg_flag", neg_cycle, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("neg_clr_at_start", neg_cycle, 1);
    for (int i = 0; i <= NUM_NODES - 1; i++) iteration(i, (i != NUM_NODES - 1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("chkit_done", done, 1);
    chk("chkit_iter", iter_idx, NUM_NODES - 1);
    chk("chkit_conv", converged, 1);
    chk("chkit_neg", neg_cycle, 0);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lim_idle_busy", busy, 0);

    // Change only on the decision cycle of iteration 0
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dec_conv_cleared", converged, 0);
    for (int c = 1; c <= 26; c++) begin
      cyc(1'b0, 1'b0, (c == 12), (c == 12));
      if (c == 13) begin
        chk("dec_iter1", iter_idx, 1);
        chk("dec_vld", seq_valid, 1);
      end
      chk("dec_done", done, (c == 25));
      if (c == 25) begin
        chk("dec_iter", iter_idx, 1);
        chk("dec_conv", converged, 1);
      end
    end

    // Update outside RUN/DRAIN is ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle_upd_busy", busy, 0);

    // Start pulsed during RUN is ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      cyc((c == 3), 1'b0, 1'b0, 1'b0);
      if (c == 4) chk("srun_beat", {step_counter, phase_counter}, 3);
      chk("srun_done", done, (c == 13));
      if (c == 13) chk("srun_iter", iter_idx, 0);
    end

    // Reset during iteration 5 RUN
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) iteration(i, 1'b1);
    for (int c = 1; c <= 3; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_iter5", iter_idx, 5);
    chk("mid_vld", seq_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_run("fresh");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
